// File: rtl/mbinit_repair_pkg.sv
// mbinit_repair_pkg: shared states, response kinds, sideband codes and code lookup for MBINIT repair
package mbinit_repair_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_REQS,
    ST_CHECK_BUSY,
    ST_SEND_RESP,
    ST_RX_END,
    ST_ERROR
  } state_e;

  typedef enum logic [1:0] {
    RESP_INIT,
    RESP_RESULT,
    RESP_DONE
  } resp_e;

  localparam int CODE_W = 4;

  localparam logic [CODE_W-1:0] RCLK_INIT_REQ    = 4'd1;
  localparam logic [CODE_W-1:0] RCLK_INIT_RESP   = 4'd2;
  localparam logic [CODE_W-1:0] RCLK_RESULT_REQ  = 4'd3;
  localparam logic [CODE_W-1:0] RCLK_RESULT_RESP = 4'd4;
  localparam logic [CODE_W-1:0] RCLK_DONE_REQ    = 4'd5;
  localparam logic [CODE_W-1:0] RCLK_DONE_RESP   = 4'd6;

  localparam logic [CODE_W-1:0] RVAL_INIT_REQ    = 4'd7;
  localparam logic [CODE_W-1:0] RVAL_INIT_RESP   = 4'd8;
  localparam logic [CODE_W-1:0] RVAL_RESULT_REQ  = 4'd9;
  localparam logic [CODE_W-1:0] RVAL_RESULT_RESP = 4'd10;
  localparam logic [CODE_W-1:0] RVAL_DONE_REQ    = 4'd11;
  localparam logic [CODE_W-1:0] RVAL_DONE_RESP   = 4'd12;

  // Request (resp=0) or response (resp=1) code for a kind in REPAIRCLK (mode=0) or REPAIRVAL (mode=1)
  function automatic logic [CODE_W-1:0] msg_code(input logic mode, input resp_e kind, input logic resp);
    logic [CODE_W-1:0] clk_c;
    logic [CODE_W-1:0] val_c;
    clk_c = kind == RESP_INIT   ? (resp ? RCLK_INIT_RESP : RCLK_INIT_REQ) :
            kind == RESP_RESULT ? (resp ? RCLK_RESULT_RESP : RCLK_RESULT_REQ) :
                                  (resp ? RCLK_DONE_RESP : RCLK_DONE_REQ);
    val_c = kind == RESP_INIT   ? (resp ? RVAL_INIT_RESP : RVAL_INIT_REQ) :
            kind == RESP_RESULT ? (resp ? RVAL_RESULT_RESP : RVAL_RESULT_REQ) :
                                  (resp ? RVAL_DONE_RESP : RVAL_DONE_REQ);
    return mode ? val_c : clk_c;
  endfunction

endpackage

// File: rtl/mbinit_watchdog.sv
// mbinit_watchdog: saturating no-progress counter that flags expiry on its last allowed cycle
module mbinit_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_EXP = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Clear wins, otherwise count while enabled and stick at the ceiling
  always_comb cnt_d = i_clear ? '0 : (i_enable && cnt_q != CNT_MAX) ? cnt_q + CNT_W'(1) : cnt_q;

  assign o_expire = i_enable && cnt_q == CNT_EXP;

  // Counter register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mbinit_repair_rx.sv
// mbinit_repair_rx: partner-side responder for the REPAIRCLK / REPAIRVAL init-result-done handshake
module mbinit_repair_rx
  import mbinit_repair_pkg::*;
#(
  parameter int SB_MSG_Width   = 4,
  parameter int RESULT_W       = 3,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_en,
  input  logic                    i_mode,
  input  logic                    i_sb_busy,
  input  logic                    i_falling_edge_busy,
  input  logic [SB_MSG_Width-1:0] i_decoded_sb_msg,
  input  logic                    i_sb_valid,
  input  logic [RESULT_W-1:0]     i_logged_results,
  output logic [RESULT_W-1:0]     o_logged_results,
  output logic [SB_MSG_Width-1:0] o_encoded_sb_msg,
  output logic                    o_msg_valid,
  output logic                    o_clear_log,
  output logic                    o_rx_end,
  output logic                    o_timeout,
  output logic                    o_unexpected_msg
);

  state_e state_q, state_d;
  resp_e  resp_q, resp_d;
  logic   mode_q, mode_d;
  logic   init_seen_q, init_seen_d;
  logic   result_seen_q, result_seen_d;
  logic   accept, unexp, expire, send;
  logic   hit_init, hit_result, hit_done;

  logic                    msg_valid_q, msg_valid_d;
  logic [SB_MSG_Width-1:0] code_q, code_d;
  logic                    clear_log_q, clear_log_d;
  logic [RESULT_W-1:0]     logged_q, logged_d;
  logic                    rx_end_q, rx_end_d;
  logic                    timeout_q, timeout_d;
  logic                    unexp_q, unexp_d;

  assign hit_init   = i_sb_valid && i_decoded_sb_msg == SB_MSG_Width'(msg_code(mode_q, RESP_INIT, 1'b0));
  assign hit_result = i_sb_valid && i_decoded_sb_msg == SB_MSG_Width'(msg_code(mode_q, RESP_RESULT, 1'b0));
  assign hit_done   = i_sb_valid && i_decoded_sb_msg == SB_MSG_Width'(msg_code(mode_q, RESP_DONE, 1'b0));

  mbinit_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clear  (!i_en || accept || state_d != state_q),
    .i_enable (state_q inside {ST_WAIT_REQS, ST_CHECK_BUSY, ST_SEND_RESP}),
    .o_expire (expire)
  );

  // Next state: an accepted request beats watchdog expiry, and i_en low beats everything
  always_comb begin
    state_d = state_q;
    resp_d  = resp_q;
    accept  = 1'b0;
    unexp   = 1'b0;
    case (state_q)
      ST_IDLE:       state_d = ST_WAIT_REQS;
      ST_WAIT_REQS: begin
        accept  = hit_init || (hit_result && init_seen_q) || (hit_done && result_seen_q);
        unexp   = (hit_result && !init_seen_q) || (hit_done && !result_seen_q);
        resp_d  = !accept ? resp_q : hit_init ? RESP_INIT : hit_result ? RESP_RESULT : RESP_DONE;
        state_d = accept ? ST_CHECK_BUSY : ST_WAIT_REQS;
      end
      ST_CHECK_BUSY: state_d = i_sb_busy ? ST_CHECK_BUSY : ST_SEND_RESP;
      ST_SEND_RESP:  state_d = !i_falling_edge_busy ? ST_SEND_RESP : resp_q == RESP_DONE ? ST_RX_END : ST_WAIT_REQS;
      default:       state_d = state_q;
    endcase
    if (expire && !accept) state_d = ST_ERROR;
    if (!i_en) state_d = ST_IDLE;
  end

  // Outputs and progress flags decoded from the next state so they line up with state occupancy
  always_comb begin
    send          = state_d == ST_SEND_RESP;
    mode_d        = (state_q == ST_IDLE && state_d == ST_WAIT_REQS) ? i_mode : mode_q;
    msg_valid_d   = send;
    code_d        = send ? SB_MSG_Width'(msg_code(mode_q, resp_q, 1'b1)) : '0;
    clear_log_d   = send && resp_q == RESP_INIT;
    logged_d      = (send && resp_q == RESP_RESULT) ? i_logged_results : '0;
    rx_end_d      = state_d == ST_RX_END;
    timeout_d     = state_d == ST_ERROR;
    unexp_d       = unexp && state_d == ST_WAIT_REQS;
    init_seen_d   = !i_en ? 1'b0 : (send && resp_q == RESP_INIT) ? 1'b1 : init_seen_q;
    result_seen_d = !i_en ? 1'b0 : !send ? result_seen_q : resp_q == RESP_RESULT ? 1'b1 :
                    resp_q == RESP_INIT ? 1'b0 : result_seen_q;
  end

  // State, context and registered outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= ST_IDLE;
      resp_q        <= RESP_INIT;
      mode_q        <= 1'b0;
      init_seen_q   <= 1'b0;
      result_seen_q <= 1'b0;
      msg_valid_q   <= 1'b0;
      code_q        <= '0;
      clear_log_q   <= 1'b0;
      logged_q      <= '0;
      rx_end_q      <= 1'b0;
      timeout_q     <= 1'b0;
      unexp_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      resp_q        <= resp_d;
      mode_q        <= mode_d;
      init_seen_q   <= init_seen_d;
      result_seen_q <= result_seen_d;
      msg_valid_q   <= msg_valid_d;
      code_q        <= code_d;
      clear_log_q   <= clear_log_d;
      logged_q      <= logged_d;
      rx_end_q      <= rx_end_d;
      timeout_q     <= timeout_d;
      unexp_q       <= unexp_d;
    end
  end

  assign o_msg_valid      = msg_valid_q;
  assign o_encoded_sb_msg = code_q;
  assign o_clear_log      = clear_log_q;
  assign o_logged_results = logged_q;
  assign o_rx_end         = rx_end_q;
  assign o_timeout        = timeout_q;
  assign o_unexpected_msg = unexp_q;

endmodule

// File: tb/tb_mbinit_repair_rx.sv
// tb_mbinit_repair_rx: table, directed and randomized checks of the MBINIT repair responder
module tb_mbinit_repair_rx;

  localparam int W  = 4;
  localparam int RW = 3;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          mode = 1'b0;
  logic          busy = 1'b0;
  logic          fall = 1'b0;
  logic          valid = 1'b0;
  logic [W-1:0]  msg = '0;
  logic [RW-1:0] logged = '0;
  logic [RW-1:0] o_logged;
  logic [W-1:0]  o_code;
  logic          o_valid, o_clear, o_end, o_to, o_unexp;

  int total = 0;
  int bad = 0;

  typedef struct {
    int code;
    int resp;
    int unx;
    int fin;
  } vec_t;

  vec_t tab[11];

  always #5 clk = ~clk;

  mbinit_repair_rx #(.SB_MSG_Width(W), .RESULT_W(RW), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk               (clk),
    .i_rst_n             (rst_n),
    .i_en                (en),
    .i_mode              (mode),
    .i_sb_busy           (busy),
    .i_falling_edge_busy (fall),
    .i_decoded_sb_msg    (msg),
    .i_sb_valid          (valid),
    .i_logged_results    (logged),
    .o_logged_results    (o_logged),
    .o_encoded_sb_msg    (o_code),
    .o_msg_valid         (o_valid),
    .o_clear_log         (o_clear),
    .o_rx_end            (o_end),
    .o_timeout           (o_to),
    .o_unexpected_msg    (o_unexp)
  );

  function automatic logic [31:0] pack(input logic v, input logic [W-1:0] c, input logic cl,
                                       input logic [RW-1:0] lg, input logic e, input logic t, input logic u);
    return 32'({v, c, cl, lg, e, t, u});
  endfunction

  function automatic logic [31:0] outs();
    return pack(o_valid, o_code, o_clear, o_logged, o_end, o_to, o_unexp);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 'h%0h want 'h%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Spec rules: which response (0 = none) a request earns, and whether it is out of order
  function automatic void predict(input int m, input int code, inout bit mi, inout bit mr,
                                  output int resp, output bit unx, output bit fin);
    int k;
    k = code - (m != 0 ? 7 : 1);
    resp = 0;
    unx = 0;
    fin = 0;
    if (k < 0 || k > 4 || k % 2 != 0) return;
    k = k / 2;
    if (k == 0 || (k == 1 && mi) || (k == 2 && mr)) begin
      resp = code + 1;
      fin = (k == 2);
      if (k == 0) begin
        mi = 1;
        mr = 0;
      end
      if (k == 1) mr = 1;
    end else unx = 1;
  endfunction

  task automatic start(input logic m);
    en = 1'b0;
    tick();
    mode = m;
    en = 1'b1;
    tick();
    chk("start_quiet", outs(), 0);
    mode = 1'($urandom_range(0, 1));
  endtask

  task automatic do_req(input int code, input int resp, input int unx, input int fin, input int nbusy, input int lr);
    int init_r, res_r;
    init_r = (resp == 2 || resp == 8) ? 1 : 0;
    res_r  = (resp == 4 || resp == 10) ? 1 : 0;
    logged = RW'(lr);
    msg = W'(code);
    valid = 1'b1;
    busy = nbusy > 0;
    tick();
    valid = 1'b0;
    msg = '0;
    chk("unexpected_pulse", o_unexp, 32'(unx));
    chk("no_valid_at_accept", o_valid, 0);
    if (resp == 0) begin
      tick();
      chk("quiet_after_nonaccept", outs(), 0);
      return;
    end
    for (int i = 0; i < nbusy; i++) begin
      busy = 1'b1;
      fall = 1'($urandom_range(0, 1));
      tick();
      chk("held_while_busy", {o_valid, o_end}, 0);
    end
    busy = 1'b0;
    fall = 1'b0;
    tick();
    chk("response", outs(), pack(1'b1, W'(resp), init_r[0], res_r[0] ? RW'(lr) : '0, 1'b0, 1'b0, 1'b0));
    busy = 1'b1;
    tick();
    chk("response_held", {o_valid, o_code}, {1'b1, W'(resp)});
    busy = 1'b0;
    fall = 1'b1;
    tick();
    fall = 1'b0;
    chk("after_sent", {o_valid, o_end}, {1'b0, fin[0]});
  endtask

  initial begin
    int n, code, resp;
    bit unx, fin, mi, mr;
    int nacc;
    logic m;

    tab = '{'{3, 0, 1, 0}, '{5, 0, 1, 0}, '{7, 0, 0, 0}, '{15, 0, 0, 0},
            '{1, 2, 0, 0}, '{5, 0, 1, 0}, '{3, 4, 0, 0}, '{1, 2, 0, 0},
            '{5, 0, 1, 0}, '{3, 4, 0, 0}, '{5, 6, 0, 1}};

    tick();
    chk("in_reset", outs(), 0);
    rst_n = 1'b1;
    tick();
    chk("after_reset_disabled", outs(), 0);

    // Mode 0 ordering table
    start(1'b0);
    for (int i = 0; i < 11; i++) do_req(tab[i].code, tab[i].resp, tab[i].unx, tab[i].fin, i % 3, 5);
    tick();
    chk("rx_end_held", {o_end, o_valid}, 2'b10);

    // Mode 1: REPAIRCLK code ignored, full sequence, busy held 5 cycles around done
    start(1'b1);
    do_req(1, 0, 0, 0, 0, 0);
    do_req(7, 8, 0, 0, 1, 3);
    do_req(9, 10, 0, 0, 0, 6);
    do_req(11, 12, 0, 1, 5, 0);

    // Timeout with busy stuck high, sticky until i_en drops
    start(1'b0);
    msg = 4'd1;
    valid = 1'b1;
    busy = 1'b1;
    tick();
    valid = 1'b0;
    n = 0;
    while (o_to !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("timeout_latency", n, 16);
    chk("timeout_only", outs(), pack(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b0));
    busy = 1'b0;
    tick();
    tick();
    chk("timeout_sticky", o_to, 1);
    en = 1'b0;
    tick();
    chk("timeout_cleared", outs(), 0);

    // Accepted request on the expiry cycle wins over the watchdog
    start(1'b0);
    for (int i = 0; i < 15; i++) tick();
    chk("no_timeout_yet", o_to, 0);
    do_req(1, 2, 0, 0, 0, 0);
    chk("request_beat_timeout", o_to, 0);

    // Asynchronous reset in the middle of SEND_RESP
    start(1'b0);
    msg = 4'd1;
    valid = 1'b1;
    busy = 1'b0;
    tick();
    valid = 1'b0;
    tick();
    chk("sending_before_reset", o_valid, 1);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", outs(), 0);
    mode = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("after_release", outs(), 0);
    do_req(3, 0, 1, 0, 0, 0);
    do_req(1, 2, 0, 0, 1, 0);

    // Randomized sessions against the rule model
    for (int s = 0; s < 12; s++) begin
      m = 1'($urandom_range(0, 1));
      start(m);
      mi = 0;
      mr = 0;
      nacc = 0;
      fin = 0;
      for (int r = 0; r < 14 && !fin; r++) begin
        if (nacc >= 4) code = m ? 7 : 1;
        else if ($urandom_range(0, 3) == 0) code = $urandom_range(0, 15);
        else code = (m ? 7 : 1) + 2 * $urandom_range(0, 2);
        predict(m, code, mi, mr, resp, unx, fin);
        do_req(code, resp, unx, fin, $urandom_range(0, 4), $urandom_range(0, 7));
        nacc = resp == 0 ? nacc + 1 : 0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
